// File: rtl/round_robin_scheduler.sv
// Ready-queue dispatcher: circular PID FIFO feeding a quantum timer, re-queuing
// preempted PIDs at the tail and dropping exited ones.
module round_robin_scheduler #(
    parameter int PID_W = 5,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enq_valid,
    input  logic [PID_W-1:0]           enq_pid,
    output logic                       enq_ready,
    input  logic                       quantum_expired,
    input  logic                       proc_exit,
    output logic                       atv_temp,
    output logic [PID_W-1:0]           pid_run,
    output logic                       ctx_switch,
    output logic [$clog2(DEPTH+1)-1:0] queue_count
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_RUN, S_SAVE} state_e;

    state_e           state_q, state_d;
    logic [PID_W-1:0] cur_q, cur_d;
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PID_W-1:0] mem_q [DEPTH];

    logic             busy, enq_fire, save_push, push, pop;
    logic [PID_W-1:0] push_data, head;

    assign busy      = (state_q != S_IDLE);
    assign save_push = (state_q == S_SAVE);
    // One slot stays reserved for the running PID so the SAVE push cannot overflow.
    assign enq_ready = !save_push && (cnt_q < (DEPTH_C - CW'(busy)));
    assign enq_fire  = enq_valid && enq_ready && (enq_pid != '0);
    assign push      = enq_fire || save_push;
    assign push_data = save_push ? cur_q : enq_pid;
    // Single-process re-dispatch: the PID being pushed is also the one popped.
    assign head      = (save_push && cnt_q == '0) ? cur_q : mem_q[rd_q];

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cnt_q != '0) begin
                    state_d = S_DISPATCH;
                    pop     = 1'b1;
                end
            end
            S_DISPATCH: state_d = S_RUN;
            S_RUN: begin
                if (proc_exit)            state_d = S_IDLE;
                else if (quantum_expired) state_d = S_SAVE;
            end
            S_SAVE: begin
                state_d = S_DISPATCH;
                pop     = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cur_d = cur_q;
        if (pop)                                  cur_d = head;
        else if (state_q == S_RUN && proc_exit)   cur_d = '0;
        wr_d  = push ? wr_q + AW'(1) : wr_q;
        rd_d  = pop  ? rd_q + AW'(1) : rd_q;
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= push_data;
    end

    assign atv_temp    = (state_q == S_DISPATCH);
    assign ctx_switch  = (state_q == S_DISPATCH);
    assign pid_run     = busy ? cur_q : '0;
    assign queue_count = cnt_q;

endmodule

// File: tb/tb_round_robin_scheduler.sv
// Directed + random bench for round_robin_scheduler against a queue-based model.
module tb_round_robin_scheduler;

    localparam int PID_W = 5;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             enq_valid = 1'b0;
    logic [PID_W-1:0] enq_pid = '0;
    logic             enq_ready;
    logic             quantum_expired = 1'b0;
    logic             proc_exit = 1'b0;
    logic             atv_temp;
    logic [PID_W-1:0] pid_run;
    logic             ctx_switch;
    logic [CW-1:0]    queue_count;

    round_robin_scheduler #(.PID_W(PID_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .enq_valid(enq_valid), .enq_pid(enq_pid), .enq_ready(enq_ready),
        .quantum_expired(quantum_expired), .proc_exit(proc_exit),
        .atv_temp(atv_temp), .pid_run(pid_run), .ctx_switch(ctx_switch),
        .queue_count(queue_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: ready queue, the PID holding the CPU (0 = none) and the
    // one-cycle dispatch / save phases around a context switch.
    int q[$];
    int cur  = 0;
    bit disp = 0;
    bit save = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic bit model_ready();
        return !save && (q.size() < DEPTH - ((cur != 0) ? 1 : 0));
    endfunction

    task automatic model_reset();
        q.delete();
        cur  = 0;
        disp = 0;
        save = 0;
    endtask

    task automatic tick(input bit v, input int p, input bit e, input bit x);
        bit acc;
        enq_valid       = v;
        enq_pid         = PID_W'(p);
        quantum_expired = e;
        proc_exit       = x;
        chk("pid_run",     32'(pid_run),     32'(cur));
        chk("atv_temp",    32'(atv_temp),    32'(disp));
        chk("ctx_switch",  32'(ctx_switch),  32'(disp));
        chk("queue_count", 32'(queue_count), 32'(q.size()));
        chk("enq_ready",   32'(enq_ready),   32'(model_ready()));
        acc = v && model_ready() && (p != 0);
        @(posedge clk);
        if (disp) begin
            disp = 0;
        end else if (save) begin
            q.push_back(cur);
            cur  = q.pop_front();
            save = 0;
            disp = 1;
        end else if (cur != 0) begin
            if (x)      cur = 0;
            else if (e) save = 1;
        end else if (q.size() > 0) begin
            cur  = q.pop_front();
            disp = 1;
        end
        if (acc) q.push_back(p);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 16; i++) tick(0, 0, 0, 1);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_pid_run",  32'(pid_run),     0);
        chk("rst_atv",      32'(atv_temp),    0);
        chk("rst_ctx",      32'(ctx_switch),  0);
        chk("rst_count",    32'(queue_count), 0);
        chk("rst_enq_rdy",  32'(enq_ready),   1);
        reset = 1'b1;

        // enqueue 3,7,9 then rotate via expiries
        tick(1, 3, 0, 0); tick(1, 7, 0, 0); tick(1, 9, 0, 0);
        idle(3);
        for (int k = 0; k < 5; k++) begin
            tick(0, 0, 1, 0);
            idle(4);
        end

        // single PID re-dispatch
        drain();
        tick(1, 5, 0, 0); idle(3);
        for (int k = 0; k < 3; k++) begin
            tick(0, 0, 1, 0);
            idle(3);
        end

        // full-queue reservation with one running process
        drain();
        tick(1, 8, 0, 0); idle(2);
        tick(1, 1, 0, 0); tick(1, 2, 0, 0); tick(1, 3, 0, 0);
        chk("full_enq_ready", 32'(enq_ready),   0);
        chk("full_count",     32'(queue_count), 3);
        tick(1, 4, 0, 0);
        for (int k = 0; k < 6; k++) begin
            tick(0, 0, 1, 0);
            idle(2);
        end

        // exit wins over expiry; PID 0 dropped
        drain();
        tick(1, 6, 0, 0); idle(2);
        tick(0, 0, 1, 1);
        idle(4);
        tick(1, 0, 0, 0);
        idle(2);
        chk("exit_pid_run", 32'(pid_run),     0);
        chk("pid0_count",   32'(queue_count), 0);

        // randomized traffic
        for (int k = 0; k < 1500; k++)
            tick(($urandom % 3) == 0, int'($urandom % 32),
                 ($urandom % 8) == 0, ($urandom % 16) == 0);

        // reset mid-RUN with two queued
        drain();
        tick(1, 10, 0, 0); tick(1, 11, 0, 0); tick(1, 12, 0, 0);
        chk("pre_rst_pid",   32'(pid_run),     10);
        chk("pre_rst_count", 32'(queue_count), 2);
        #2 reset = 1'b0;
        #1;
        chk("async_pid_run", 32'(pid_run),     0);
        chk("async_count",   32'(queue_count), 0);
        chk("async_atv",     32'(atv_temp),    0);
        chk("async_enq_rdy", 32'(enq_ready),   1);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        idle(5);
        tick(1, 13, 0, 0);
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
